// File: rtl/imm_gen_q_pkg.sv
// Shared definitions for the buffered immediate generator.
// Holds the instruction-type encodings, the type field width, the default
// datapath width and the XLEN-independent part of a queue entry.
package imm_gen_q_pkg;

  localparam int unsigned TYPE_W       = 3;
  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [TYPE_W-1:0] {
    IT_R   = 3'd0,
    IT_I   = 3'd1,
    IT_S   = 3'd2,
    IT_B   = 3'd3,
    IT_U   = 3'd4,
    IT_J   = 3'd5,
    IT_Z   = 3'd6,
    IT_ILL = 3'd7
  } itype_t;

  // Leading fields of a queue entry; the top appends the XLEN-wide imm so
  // the full entry reads {illegal, itype, imm}.
  typedef struct packed {
    logic   illegal;
    itype_t itype;
  } entry_meta_t;

endpackage

// File: rtl/imm_slice.sv
// Combinational immediate extraction.
// Ports:
//   inst    - raw 32-bit instruction word
//   itype   - decoded instruction type
//   imm     - XLEN-wide extended immediate (0 for R and illegal types)
//   illegal - itype is the reserved encoding
module imm_slice
  import imm_gen_q_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]       inst,
  input  logic [TYPE_W-1:0] itype,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  itype_t t;
  assign t = itype_t'(itype);

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  // Signed fields so a width cast performs the sign extension.
  logic signed [11:0] i_field;
  logic signed [11:0] s_field;
  logic signed [12:0] b_field;
  logic signed [31:0] u_field;
  logic signed [20:0] j_field;

  assign i_field = inst[31:20];
  assign s_field = {inst[31:25], inst[11:7]};
  assign b_field = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_field = {inst[31:12], 12'b0};
  assign j_field = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (t)
      IT_R:    imm = '0;
      IT_I:    imm = XLEN'(i_field);
      IT_S:    imm = XLEN'(s_field);
      IT_B:    imm = XLEN'(b_field);
      IT_U:    imm = XLEN'(u_field);
      IT_J:    imm = XLEN'(j_field);
      IT_Z:    imm = XLEN'(inst[19:15]);
      IT_ILL:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_q.sv
// Buffered immediate generator: extracts the immediate of each accepted
// instruction and queues {illegal, itype, imm} in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   flush               - synchronous queue clear (error state kept)
//   in_valid/in_ready   - input handshake for inst/itype
//   out_valid/out_ready - output handshake for the queue head
//   imm, out_itype, out_illegal - head entry fields
//   err, err_inst       - sticky illegal flag and first offending inst
//   count               - occupied entries
module imm_gen_q
  import imm_gen_q_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                inst,
  input  logic [TYPE_W-1:0]          itype,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            imm,
  output logic [TYPE_W-1:0]          out_itype,
  output logic                       out_illegal,
  output logic                       err,
  output logic [31:0]                err_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    entry_meta_t          meta;
    logic [XLEN-1:0]      imm;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [XLEN-1:0]    slice_imm;
  logic               slice_illegal;
  logic               push;
  logic               pop;
  entry_t             new_entry;
  entry_t             head;

  imm_slice #(.XLEN(XLEN)) u_slice (
    .inst    (inst),
    .itype   (itype),
    .imm     (slice_imm),
    .illegal (slice_illegal)
  );

  // Handshakes: in_ready depends only on occupancy and flush.
  assign in_ready  = (count < CNT_W'(DEPTH)) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry              = '0;
    new_entry.meta.illegal = slice_illegal;
    new_entry.meta.itype   = itype_t'(itype);
    new_entry.imm          = slice_imm;
  end

  // Head fields come straight from queue storage, never from the inputs.
  assign head        = mem[rd_ptr];
  assign imm         = head.imm;
  assign out_itype   = head.meta.itype;
  assign out_illegal = head.meta.illegal;

  // Queue storage, pointers and occupancy; pointers wrap mod DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky error; err_inst captures only the first illegal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_inst <= '0;
    end else if (push && slice_illegal) begin
      err <= 1'b1;
      if (!err) err_inst <= inst;
    end
  end

endmodule

// File: tb/tb_imm_gen_q.sv
// Bench for imm_gen_q: a 32-bit and a 64-bit instance share one stimulus
// stream and are checked every cycle against a queue-based reference model.
module tb_imm_gen_q;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0]  itype = '0;
  logic        out_ready = 1'b0;

  logic          in_ready32, out_valid32, out_illegal32, err32;
  logic [31:0]   imm32, err_inst32;
  logic [2:0]    out_itype32;
  logic [CW-1:0] count32;

  logic          in_ready64, out_valid64, out_illegal64, err64;
  logic [63:0]   imm64;
  logic [31:0]   err_inst64;
  logic [2:0]    out_itype64;
  logic [CW-1:0] count64;

  imm_gen_q #(.XLEN(32), .DEPTH(DEPTH)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .inst(inst), .itype(itype), .out_valid(out_valid32),
    .out_ready(out_ready), .imm(imm32), .out_itype(out_itype32),
    .out_illegal(out_illegal32), .err(err32), .err_inst(err_inst32), .count(count32)
  );

  imm_gen_q #(.XLEN(64), .DEPTH(DEPTH)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .inst(inst), .itype(itype), .out_valid(out_valid64),
    .out_ready(out_ready), .imm(imm64), .out_itype(out_itype64),
    .out_illegal(out_illegal64), .err(err64), .err_inst(err_inst64), .count(count64)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference immediate, always computed at 64 bits; the low half is the 32-bit answer.
  function automatic logic [63:0] ref_imm(input logic [2:0] t, input logic [31:0] i);
    longint v;
    case (t)
      3'd1: v = longint'($signed(i[31:20]));
      3'd2: v = longint'($signed({i[31:25], i[11:7]}));
      3'd3: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4: v = longint'($signed(i[31:12])) * 4096;
      3'd5: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      3'd6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  t;
    logic        ill;
  } mentry_t;

  mentry_t     mq[$];
  logic        m_err = 1'b0;
  logic [31:0] m_err_inst = '0;

  // Reference model: decides its own accept/consume from its own occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_err      = 1'b0;
      m_err_inst = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      automatic bit do_pop  = (mq.size() > 0) && out_ready;
      automatic bit do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        automatic mentry_t e;
        e.imm = ref_imm(itype, inst);
        e.t   = itype;
        e.ill = (itype == 3'd7);
        mq.push_back(e);
        if (e.ill) begin
          if (!m_err) m_err_inst = inst;
          m_err = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    automatic int sz = mq.size();
    check("out_valid32", 64'(out_valid32), 64'(sz != 0));
    check("out_valid64", 64'(out_valid64), 64'(sz != 0));
    check("count32", 64'(count32), 64'(sz));
    check("count64", 64'(count64), 64'(sz));
    check("in_ready32", 64'(in_ready32), 64'((sz < DEPTH) && !flush));
    check("in_ready64", 64'(in_ready64), 64'((sz < DEPTH) && !flush));
    check("err32", 64'(err32), 64'(m_err));
    check("err64", 64'(err64), 64'(m_err));
    check("err_inst32", 64'(err_inst32), 64'(m_err_inst));
    check("err_inst64", 64'(err_inst64), 64'(m_err_inst));
    if (sz != 0) begin
      check("imm32", 64'(imm32), 64'(mq[0].imm[31:0]));
      check("imm64", imm64, mq[0].imm);
      check("out_itype32", 64'(out_itype32), 64'(mq[0].t));
      check("out_itype64", 64'(out_itype64), 64'(mq[0].t));
      check("out_illegal32", 64'(out_illegal32), 64'(mq[0].ill));
      check("out_illegal64", 64'(out_illegal64), 64'(mq[0].ill));
    end
  end

  // Push one entry into an empty queue, check the head literally, then pop it.
  task automatic single(input logic [2:0] t, input logic [31:0] w, input logic [63:0] exp);
    in_valid = 1'b1; itype = t; inst = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lit_valid", 64'(out_valid32 & out_valid64), 64'(1));
    check("lit_imm32", 64'(imm32), 64'(exp[31:0]));
    check("lit_imm64", imm64, exp);
    check("lit_itype", 64'(out_itype64), 64'(t));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_out_valid", 64'(out_valid32 | out_valid64), 64'(0));
    check("rst_in_ready", 64'(in_ready32 & in_ready64), 64'(1));
    check("rst_imm", imm64 | 64'(imm32), 64'(0));
    check("rst_itype", 64'(out_itype32 | out_itype64), 64'(0));
    check("rst_illegal", 64'(out_illegal32 | out_illegal64), 64'(0));
    check("rst_err", 64'(err32 | err64), 64'(0));
    check("rst_err_inst", 64'(err_inst32 | err_inst64), 64'(0));
    check("rst_count", 64'(count32 | count64), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Extraction vectors
    single(3'd1, 32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF);
    single(3'd3, 32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC);
    single(3'd5, 32'h001000EF, 64'h00000000_00000800);
    single(3'd6, 32'h000F8073, 64'h00000000_0000001F);
    single(3'd4, 32'h800000B7, 64'hFFFFFFFF_80000000);
    single(3'd4, 32'h123450B7, 64'h00000000_12345000);

    // Back-pressure: R, I, S with consumer stalled
    in_valid = 1'b1; itype = 3'd0; inst = 32'h00000033;
    @(posedge clk); #1;
    itype = 3'd1; inst = 32'h00500093;
    @(posedge clk); #1;
    itype = 3'd2; inst = 32'hFE112E23;
    check("full_in_ready", 64'(in_ready32 | in_ready64), 64'(0));
    check("full_count", 64'(count64), 64'(2));
    @(posedge clk); #1;
    check("held_count", 64'(count32), 64'(2));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      automatic bit acc = in_valid && in_ready32;
      check("order_valid", 64'(out_valid32), 64'(1));
      check("order_itype", 64'(out_itype32), 64'(k));
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("drained", 64'(count32 | count64), 64'(0));
    check("drained_in_valid", 64'(in_valid), 64'(0));
    out_ready = 1'b0;

    // Illegal entries and sticky error
    in_valid = 1'b1; itype = 3'd7; inst = 32'hDEADBEEF;
    @(posedge clk); #1;
    inst = 32'h12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ill_head", 64'(out_illegal32 & out_illegal64), 64'(1));
    check("ill_imm", imm64, 64'(0));
    check("ill_err", 64'(err32 & err64), 64'(1));
    check("ill_err_inst", 64'(err_inst64), 64'hDEADBEEF);
    flush = 1'b1; in_valid = 1'b1; itype = 3'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count32), 64'(0));
    check("flush_err", 64'(err32), 64'(1));
    check("flush_err_inst", 64'(err_inst32), 64'hDEADBEEF);

    // Asynchronous reset with two entries queued
    in_valid = 1'b1; itype = 3'd2; inst = 32'h00A12423;
    @(posedge clk); #1;
    itype = 3'd1; inst = 32'h00100113;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_count", 64'(count64), 64'(2));
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid32 | out_valid64), 64'(0));
    check("arst_count", 64'(count32 | count64), 64'(0));
    check("arst_err", 64'(err32 | err64), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; itype = 3'd6; inst = 32'h00018073;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_count", 64'(count32), 64'(1));
    check("post_rst_imm", 64'(imm32), 64'h3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_alone", 64'(count32 | count64), 64'(0));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      itype     = 3'($urandom_range(0, 7));
      inst      = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_q.md
# imm_gen_q

Parametrised, buffered successor to the combinational immediate extender. It takes a raw instruction word and its decoded instruction type from the decoder, then forms the XLEN-wide immediate, including the new CSR zimm type. Results go into a DEPTH-entry output queue with valid/ready handshakes on both sides. Illegal types are flagged in-band and latched in a sticky error register instead of aborting the simulation.

## Interface
- XLEN, 32: immediate/datapath width; legal values 32 or 64.
- DEPTH, 2: output queue entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue flush; does not clear error state.
- in_valid  in  1  instruction/type pair offered.
- in_ready  out  1  queue can accept this cycle.
- inst  in  32  raw instruction word.
- itype  in  3  instruction type (R=0, I=1, S=2, B=3, U=4, J=5, Z=6; 7 illegal).
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer takes head this cycle.
- imm  out  XLEN  immediate of head entry.
- out_itype  out  3  itype of head entry.
- out_illegal  out  1  head entry had illegal itype.
- err  out  1  sticky: an illegal itype was ever accepted.
- err_inst  out  32  inst of first illegal entry accepted since reset.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Accept when in_valid && in_ready. Consume when out_valid && out_ready. in_ready = (count < DEPTH) && !flush.
- Extraction uses inst bits directly; sext means sign-extend to XLEN:
  - R: 0.
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 replicate inst[31].
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Z: zero-extend inst[19:15].
- itype 7: imm=0 and out_illegal=1; the entry is still queued in order.
  - On its accept, err is set.
  - err_inst is loaded only if err was 0. Later illegal entries do not overwrite it.
- Queue: circular buffer with wrapping read/write pointers (mod DEPTH) plus the count register.
  - Push-only: count+1. Pop-only: count−1. Both in the same cycle: count unchanged.
- Full: in_ready=0. Push in the same cycle as a pop when full is not allowed.
- Empty: out_valid=0. imm, out_itype and out_illegal hold the last head value and are don't-care.
- flush: next cycle count=0, pointers=0, out_valid=0. An input offered in the flush cycle is not accepted. err and err_inst are untouched.

## Timing
- Reset (async assert, sync release):
  - count=0, pointers=0, out_valid=0, in_ready=1.
  - imm=0, out_itype=0, out_illegal=0.
  - err=0, err_inst=0.
- Latency: an entry accepted at edge t is presented with out_valid=1 after edge t (cycle t+1), when the queue was empty.
- Throughput: one accept and one consume per cycle in steady state.
- Output ordering is strictly FIFO.
- out_valid, imm, out_itype and out_illegal are registered or derived only from queue state; there is no combinational path from inst/itype.
- in_ready depends only on count and flush; there is no combinational path from out_ready.
- Reset mid-operation drops all queued entries immediately.

## Structure
- Shared defines/package holds:
  - itype encodings and the TYPE width (3);
  - the XLEN default;
  - the queue entry layout {illegal, itype, imm}.
- Sub-module imm_slice: combinational (inst, itype) → (imm, illegal), parametrised by XLEN.
- The top level holds the queue, pointers, count and error registers.

## Test plan
- XLEN=32, I, inst=0xFFF00093 → next cycle out_valid=1, imm=0xFFFFFFFF, out_itype=1.
- B, inst=0xFE000EE3 → imm=0xFFFFFFFC. J, inst=0x001000EF → imm=0x00000800. Z, inst=0x000F8073 → imm=0x0000001F.
- XLEN=64, U, inst=0x800000B7 → imm=0xFFFFFFFF80000000. U, inst=0x123450B7 → imm=0x0000000012345000.
- DEPTH=2, out_ready=0, push R, I, S back-to-back:
  - in_ready drops after the 2nd accept and the 3rd offer is held;
  - count=2;
  - raise out_ready → outputs in order R, I, S, with no loss or duplicates.
- itype=7 with inst=0xDEADBEEF, then itype=7 with inst=0x12345678:
  - both emerge with out_illegal=1 and imm=0;
  - err=1, err_inst=0xDEADBEEF;
  - flush leaves err set;
  - only rst_n low clears it.
- Queue holds 2 entries and rst_n is asserted asynchronously mid-cycle → out_valid=0, count=0 immediately; after release, a new push emerges alone.
